// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: write strobe and read handshake bundle for uart_rx_fifo.
//   Write side : data_ready, rx_data, parity_err, frame_err (from uart_rx)
//   Read side  : rd_valid, rd_ready, rd_data, rd_parity_err, rd_frame_err
//   master     : the producer/consumer environment around the FIFO
//   slave      : the FIFO itself
interface uart_rx_fifo_if #(
    parameter int unsigned DATA_W = 8
);
    logic              data_ready;
    logic [DATA_W-1:0] rx_data;
    logic              parity_err;
    logic              frame_err;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_parity_err;
    logic              rd_frame_err;

    modport master (
        output data_ready, rx_data, parity_err, frame_err, rd_ready,
        input  rd_valid, rd_data, rd_parity_err, rd_frame_err
    );

    modport slave (
        input  data_ready, rx_data, parity_err, frame_err, rd_ready,
        output rd_valid, rd_data, rd_parity_err, rd_frame_err
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer behind uart_rx. Captures {frame_err, parity_err, rx_data}
// on each data_ready cycle and presents entries through a first-word-fall-through
// valid/ready read port.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   bus (slave)   : write strobe/data/flags in, FWFT read port out
//   level         : stored entries, 0..DEPTH
//   full, empty   : level == DEPTH, level == 0
//   overflow      : sticky, a byte was dropped because the FIFO was full
//   overflow_clr  : clears overflow (a same-cycle overflow event wins)
//   err_drop_cnt  : (UART_RX_FIFO_DROP_ERR_EN only) saturating count of dropped error frames
// Optional feature macro: UART_RX_FIFO_DROP_ERR_EN -- when defined, bytes with a parity or
// frame error are discarded instead of stored and the read-side error flags are tied 0.
module uart_rx_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    uart_rx_fifo_if.slave          bus,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    input  logic                   overflow_clr
`ifdef UART_RX_FIFO_DROP_ERR_EN
    ,
    output logic [7:0]             err_drop_cnt
`endif
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef logic [DATA_W+1:0] entry_t;

    entry_t      mem [DEPTH];
    entry_t      head;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        overflow_q, overflow_d;
    logic        push, pop, err_frame, ovf_event;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level    = wr_ptr_q - rd_ptr_q;
    assign overflow = overflow_q;

`ifdef UART_RX_FIFO_DROP_ERR_EN
    assign err_frame = bus.parity_err | bus.frame_err;
`else
    assign err_frame = 1'b0;
`endif

    always_comb begin
        pop       = !empty && bus.rd_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
        push      = bus.data_ready && !err_frame && (!full || pop);
        ovf_event = bus.data_ready && !err_frame && full && !pop;
        wr_ptr_d  = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d  = rd_ptr_q + (AW+1)'(pop);
        overflow_d = overflow_q;
        if (ovf_event) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately not reset; the read port masks it while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= {bus.frame_err, bus.parity_err, bus.rx_data};
        end
    end

    assign head         = mem[rd_ptr_q[AW-1:0]];
    assign bus.rd_valid = !empty;
    assign bus.rd_data  = empty ? '0 : head[DATA_W-1:0];

`ifdef UART_RX_FIFO_DROP_ERR_EN
    logic [7:0] err_cnt_q;
    logic       unused_head_flags;

    // Error frames never reach storage, so the stored flag bits are always 0.
    assign unused_head_flags = ^head[DATA_W+1:DATA_W];
    assign bus.rd_parity_err = 1'b0;
    assign bus.rd_frame_err  = 1'b0;
    assign err_drop_cnt      = err_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt_q <= 8'd0;
        end else if (overflow_clr) begin
            err_cnt_q <= 8'd0;
        end else if (bus.data_ready && err_frame && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end
`else
    assign bus.rd_parity_err = empty ? 1'b0 : head[DATA_W];
    assign bus.rd_frame_err  = empty ? 1'b0 : head[DATA_W+1];
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: self-checking bench for uart_rx_fifo (DEPTH=16, DATA_W=8).
// Directed table vectors, hand-written full/overflow/reset sequences and randomized traffic,
// all checked against a queue-based reference model. Honours UART_RX_FIFO_DROP_ERR_EN.
module tb_uart_rx_fifo;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned DATA_W = 8;
`ifdef UART_RX_FIFO_DROP_ERR_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] level;
    logic       full, empty, overflow, overflow_clr;
`ifdef UART_RX_FIFO_DROP_ERR_EN
    logic [7:0] err_drop_cnt;
`endif

    uart_rx_fifo_if #(.DATA_W(DATA_W)) bus ();

    uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .level        (level),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
`ifdef UART_RX_FIFO_DROP_ERR_EN
        ,
        .err_drop_cnt (err_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: queue of {frame_err, parity_err, data}.
    logic [9:0] mq[$];
    bit         m_ovf;
    int         m_cnt;

    function automatic void model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_cnt = 0;
    endfunction

    function automatic void model_step(bit dr, logic [7:0] d, bit pe, bit fe, bit rr, bit clr);
        bit err, was_full, do_pop, accept, ovf_ev;
        err      = DROP && (pe || fe);
        was_full = (mq.size() == DEPTH);
        do_pop   = (mq.size() != 0) && rr;
        accept   = dr && !err && (!was_full || do_pop);
        ovf_ev   = dr && !err && was_full && !do_pop;
        if (clr) m_cnt = 0;
        else if (dr && err && m_cnt < 255) m_cnt++;
        if (do_pop) void'(mq.pop_front());
        if (accept) mq.push_back({fe, pe, d});
        if (ovf_ev) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic check_all(string tag);
        int         n;
        logic [9:0] h;
        n = mq.size();
        h = (n != 0) ? mq[0] : 10'd0;
        chk({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(n != 0));
        chk({tag, ".rd_data"}, 32'(bus.rd_data), 32'(h[7:0]));
        chk({tag, ".rd_parity_err"}, 32'(bus.rd_parity_err), 32'(h[8]));
        chk({tag, ".rd_frame_err"}, 32'(bus.rd_frame_err), 32'(h[9]));
        chk({tag, ".level"}, 32'(level), 32'(n));
        chk({tag, ".full"}, 32'(full), 32'(n == DEPTH));
        chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
`ifdef UART_RX_FIFO_DROP_ERR_EN
        chk({tag, ".err_drop_cnt"}, 32'(err_drop_cnt), 32'(m_cnt));
`endif
    endtask

    // Drive one cycle of inputs, clock it, then compare against the model.
    task automatic cycle(string tag, bit dr, logic [7:0] d, bit pe, bit fe, bit rr, bit clr);
        bus.data_ready = dr;
        bus.rx_data    = d;
        bus.parity_err = pe;
        bus.frame_err  = fe;
        bus.rd_ready   = rr;
        overflow_clr   = clr;
        model_step(dr, d, pe, fe, rr, clr);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    typedef struct {
        bit         dr;
        logic [7:0] d;
        bit         pe;
        bit         fe;
        bit         rr;
        bit         e_valid;
        logic [7:0] e_data;
        bit         e_pe;
        bit         e_fe;
        int         e_level;
    } vec_t;

    function automatic vec_t mk(bit dr, logic [7:0] d, bit pe, bit fe, bit rr,
                                bit ev, logic [7:0] ed, bit epe, bit efe, int el);
        vec_t v;
        v.dr = dr; v.d = d; v.pe = pe; v.fe = fe; v.rr = rr;
        v.e_valid = ev; v.e_data = ed; v.e_pe = epe; v.e_fe = efe; v.e_level = el;
        return v;
    endfunction

    vec_t vecs[7];

    initial begin
        vecs[0] = mk(1'b1, 8'h4E, 1'b0, 1'b0, 1'b0, 1'b1, 8'h4E, 1'b0, 1'b0, 1);
        vecs[1] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0);
        if (DROP) begin
            vecs[2] = mk(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0);
            vecs[4] = mk(1'b1, 8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0);
        end else begin
            vecs[2] = mk(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 1);
            vecs[4] = mk(1'b1, 8'h12, 1'b1, 1'b0, 1'b0, 1'b1, 8'h12, 1'b1, 1'b0, 1);
        end
        vecs[3] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0);
        // Off: pop 0x12 and push 0x34 together. On: rd_ready on empty is ignored.
        vecs[5] = mk(1'b1, 8'h34, 1'b0, 1'b0, 1'b1, 1'b1, 8'h34, 1'b0, 1'b0, 1);
        vecs[6] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0);

        reset          = 1'b1;
        bus.data_ready = 1'b0;
        bus.rx_data    = 8'h00;
        bus.parity_err = 1'b0;
        bus.frame_err  = 1'b0;
        bus.rd_ready   = 1'b0;
        overflow_clr   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_all("reset");
        chk("reset.rd_data", 32'(bus.rd_data), 32'h0);
        chk("reset.empty", 32'(empty), 32'h1);

        for (int i = 0; i < 7; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            cycle(t, vecs[i].dr, vecs[i].d, vecs[i].pe, vecs[i].fe, vecs[i].rr, 1'b0);
            chk({t, ".valid"}, 32'(bus.rd_valid), 32'(vecs[i].e_valid));
            chk({t, ".data"}, 32'(bus.rd_data), 32'(vecs[i].e_data));
            chk({t, ".pe"}, 32'(bus.rd_parity_err), 32'(vecs[i].e_pe));
            chk({t, ".fe"}, 32'(bus.rd_frame_err), 32'(vecs[i].e_fe));
            chk({t, ".level"}, 32'(level), 32'(vecs[i].e_level));
        end
`ifdef UART_RX_FIFO_DROP_ERR_EN
        chk("vec.err_drop_cnt", 32'(err_drop_cnt), 32'd2);
        cycle("cnt_clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("cnt_clr.err_drop_cnt", 32'(err_drop_cnt), 32'd0);
`endif

        // Fill, overflow with a same-cycle clear (set wins), sticky, then clear.
        for (int i = 1; i <= 16; i++) cycle("fill", 1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("fill.full", 32'(full), 32'h1);
        chk("fill.level", 32'(level), 32'd16);
        cycle("ovf_set", 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovf_set.overflow", 32'(overflow), 32'h1);
        chk("ovf_set.level", 32'(level), 32'd16);
        cycle("ovf_hold", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovf_hold.overflow", 32'(overflow), 32'h1);
        for (int i = 1; i <= 16; i++) begin
            chk("drain1.order", 32'(bus.rd_data), 32'(i));
            cycle("drain1", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        chk("drain1.empty", 32'(empty), 32'h1);
        cycle("ovf_clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovf_clr.overflow", 32'(overflow), 32'h0);

        // Full FIFO with simultaneous push and pop.
        for (int i = 1; i <= 16; i++) cycle("fill2", 1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("full_pp", 1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("full_pp.level", 32'(level), 32'd16);
        chk("full_pp.overflow", 32'(overflow), 32'h0);
        chk("full_pp.head", 32'(bus.rd_data), 32'h02);
        for (int i = 2; i <= 17; i++) begin
            chk("drain2.order", 32'(bus.rd_data), (i == 17) ? 32'hAA : 32'(i));
            cycle("drain2", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        end

        // Reset mid-stream, with a data_ready coinciding with the assertion.
        for (int i = 0; i < 3; i++) cycle("pre_rst", 1'b1, 8'(8'h61 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        bus.data_ready = 1'b1;
        bus.rx_data    = 8'h77;
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("rst_async");
        chk("rst_async.level", 32'(level), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_all("rst_hold");
            chk("rst_hold.rd_valid", 32'(bus.rd_valid), 32'h0);
        end
        bus.data_ready = 1'b0;
        reset          = 1'b0;
        cycle("post_rst", 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst.rd_data", 32'(bus.rd_data), 32'h33);
        chk("post_rst.level", 32'(level), 32'd1);

        // Randomized traffic; phases alternate between filling and draining bias.
        for (int i = 0; i < 3000; i++) begin
            bit fillp;
            bit dr, rr, pe, fe, clr;
            fillp = ((i / 150) % 2) == 0;
            dr  = fillp ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
            rr  = fillp ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
            pe  = ($urandom_range(7) == 0);
            fe  = ($urandom_range(7) == 0);
            clr = ($urandom_range(31) == 0);
            cycle("rand", dr, 8'($urandom), pe, fe, rr, clr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
